// File: rtl/fs4_serial.sv
// Bit-serial unsigned subtractor: computes A - B - Bin one bit per clock, LSB first,
// with a Start/Busy/Done handshake and registered Diff/Bout/Zero results.
module fs4_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d;

  logic             bit_d, br_nxt;
  logic [WIDTH-1:0] res_shift;

  // Single full-subtractor cell working on the current LSBs.
  assign bit_d     = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_shift = {bit_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (Start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_shift;
          bout_d  = br_nxt;
          zero_d  = (res_shift == '0);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_fs4_serial.sv
// Self-checking bench for fs4_serial: directed table, handshake corner cases,
// exhaustive 4-bit sweep and random 8-bit vectors against an arithmetic model.
module tb_fs4_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, bin4, busy4, done4, bout4, zero4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8, zero8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fs4_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Start(start4), .A(a4), .B(b4), .Bin(bin4),
    .Busy(busy4), .Done(done4), .Diff(diff4), .Bout(bout4), .Zero(zero4)
  );

  fs4_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Busy(busy8), .Done(done8), .Diff(diff8), .Bout(bout8), .Zero(zero8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, {31'd0, busy4}, 32'd0);
    check({tag, " done"}, {31'd0, done4}, 32'd0);
    check({tag, " diff"}, {28'd0, diff4}, 32'd0);
    check({tag, " bout"}, {31'd0, bout4}, 32'd0);
    check({tag, " zero"}, {31'd0, zero4}, 32'd1);
  endtask

  // Launches one 4-bit operation and returns at the negedge inside the Done cycle.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     input bit chk_timing);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
    for (int i = 0; i < 4; i++) begin
      if (chk_timing) begin
        check("busy during run", {31'd0, busy4}, 32'd1);
        check("no done during run", {31'd0, done4}, 32'd0);
      end
      @(negedge clk);
    end
    check("done pulse", {31'd0, done4}, 32'd1);
    if (chk_timing) check("busy low at done", {31'd0, busy4}, 32'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] m;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    m = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    check("w8 done", {31'd0, done8}, 32'd1);
    check("w8 diff", {24'd0, diff8}, {24'd0, m[7:0]});
    check("w8 bout", {31'd0, bout8}, {31'd0, m[8]});
    check("w8 zero", {31'd0, zero8}, {31'd0, m[7:0] == 8'd0});
  endtask

  initial begin
    logic [4:0] m4;
    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 4'hE,  1'b1, 1'b0};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
    vecs[3] = '{4'd7,  4'd7,  1'b0, 4'd0,  1'b0, 1'b1};
    vecs[4] = '{4'd15, 4'd1,  1'b0, 4'd14, 1'b0, 1'b0};
    vecs[5] = '{4'd8,  4'd8,  1'b1, 4'hF,  1'b1, 1'b0};
    vecs[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
    vecs[7] = '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0, 1'b0};

    start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("initial reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1);
      check("table diff", {28'd0, diff4}, {28'd0, vecs[i].diff});
      check("table bout", {31'd0, bout4}, {31'd0, vecs[i].bout});
      check("table zero", {31'd0, zero4}, {31'd0, vecs[i].zero});
      @(negedge clk);
      check("done one cycle", {31'd0, done4}, 32'd0);
      check("result holds", {28'd0, diff4}, {28'd0, vecs[i].diff});
    end

    // Start while busy: second request at T0+2 is dropped.
    @(negedge clk);
    start4 = 1; a4 = 4'd9; b4 = 4'd2; bin4 = 0;
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    start4 = 1; a4 = 4'd1; b4 = 4'd8;
    @(negedge clk);
    start4 = 0;
    check("busy with ignored start", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("busy-start done", {31'd0, done4}, 32'd1);
    check("busy-start diff", {28'd0, diff4}, 32'd7);
    check("busy-start bout", {31'd0, bout4}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no second done", {31'd0, done4 | busy4}, 32'd0);
    end

    // Back-to-back with Start held high.
    start4 = 1; a4 = 4'd12; b4 = 4'd4; bin4 = 0;
    repeat (5) @(negedge clk);
    check("b2b first done", {31'd0, done4}, 32'd1);
    check("b2b first diff", {28'd0, diff4}, 32'd8);
    check("b2b first bout", {31'd0, bout4}, 32'd0);
    a4 = 4'd4; b4 = 4'd12;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b gap", {31'd0, done4}, 32'd0);
      check("b2b busy", {31'd0, busy4}, 32'd1);
    end
    @(negedge clk);
    start4 = 0;
    check("b2b second done", {31'd0, done4}, 32'd1);
    check("b2b second diff", {28'd0, diff4}, 32'd8);
    check("b2b second bout", {31'd0, bout4}, 32'd1);
    @(negedge clk);

    // Reset mid-operation at T0+2.
    op4(4'd3, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    start4 = 1; a4 = 4'd9; b4 = 4'd2;
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-op reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no done after abort", {31'd0, done4}, 32'd0);
      check("diff stays reset", {28'd0, diff4}, 32'd0);
      check("zero stays reset", {31'd0, zero4}, 32'd1);
    end
    op4(4'd15, 4'd1, 1'b0, 1'b1);
    check("post-reset diff", {28'd0, diff4}, 32'd14);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea, eb;
      logic       ebin;
      ea = i[3:0]; eb = i[7:4]; ebin = i[8];
      m4 = {1'b0, ea} - {1'b0, eb} - {4'd0, ebin};
      op4(ea, eb, ebin, 1'b0);
      check("sweep diff", {28'd0, diff4}, {28'd0, m4[3:0]});
      check("sweep bout", {31'd0, bout4}, {31'd0, m4[4]});
      check("sweep zero", {31'd0, zero4}, {31'd0, m4[3:0] == 4'd0});
    end

    // Random 8-bit vectors plus a few edges.
    op8(8'd0, 8'd0, 1'b0);
    op8(8'd0, 8'd255, 1'b1);
    op8(8'd255, 8'd254, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom;
      op8(r[7:0], r[15:8], r[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
